// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the BCD ALU sequencer.
// Operand format: sign-magnitude BCD, [8]=sign, [7:4]=tens, [3:0]=ones.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_DIV0  = 2'b01,
    ERR_DIGIT = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic       sign;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd9_t;

  // Magnitude-only test; callers pass {tens, ones}.
  function automatic logic is_zero_mag(logic [7:0] mag);
    return (mag == 8'd0);
  endfunction

  // Unknown opcodes fall back to addition.
  function automatic logic [2:0] norm_opcode(logic [2:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: return opc;
      default:                        return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bcd_operand_check.sv
// Combinational operand screen: divide-by-zero, plus non-BCD digit detection
// when ALU_SEQ_DIGIT_CHECK_EN is defined. Divide-by-zero wins when both apply.
module bcd_operand_check
  import alu_seq_pkg::*;
(
  input  logic [8:0] op1,
  input  logic [8:0] op2,
  input  logic [2:0] opcode,
  output err_e       err
);

  bcd9_t a;
  bcd9_t b;
  logic  div0;
  logic  bad_digit;
  logic  unused_signs;

  assign a = op1;
  assign b = op2;
  assign unused_signs = a.sign ^ b.sign;
  assign div0 = (opcode == OP_DIV) && is_zero_mag({b.tens, b.ones});

`ifdef ALU_SEQ_DIGIT_CHECK_EN
  assign bad_digit = (a.tens > 4'd9) || (a.ones > 4'd9) ||
                     (b.tens > 4'd9) || (b.ones > 4'd9);
`else
  logic unused_digits;
  assign unused_digits = ^{a.tens, a.ones};
  assign bad_digit     = 1'b0;
`endif

  always_comb begin
    err = ERR_NONE;
    if (div0) begin
      err = ERR_DIV0;
    end else if (bad_digit) begin
      err = ERR_DIGIT;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one BCD ALU operation at a time: accept, screen, hold ALU inputs
// ALU_WAIT cycles, capture into the accumulator. Optional: ALU_SEQ_DIGIT_CHECK_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_op1,
  input  logic [8:0] in_op2,
  input  logic [2:0] in_opcode,
  input  logic       in_use_acc,
  output logic [8:0] alu_op1,
  output logic [8:0] alu_op2,
  output logic [2:0] alu_opcode,
  input  logic [8:0] alu_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_result,
  output logic [1:0] out_err,
  output logic       busy
);

  localparam int               CNT_W    = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_WAIT - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [8:0]       acc_reg, acc_next;
  logic [8:0]       alu_op1_reg, alu_op1_next;
  logic [8:0]       alu_op2_reg, alu_op2_next;
  logic [2:0]       alu_opcode_reg, alu_opcode_next;
  logic [8:0]       result_reg, result_next;
  err_e             err_reg, err_next;
  err_e             pend_reg, pend_next;
  err_e             chk_err;
  logic             accept;
  logic [8:0]       sel_op1;
  logic [8:0]       capture;

  assign in_ready   = (state_reg == IDLE) && !clr;
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == DONE);
  assign accept     = in_valid && in_ready;
  assign sel_op1    = in_use_acc ? acc_reg : in_op1;
  // A zero magnitude is always reported as +00.
  assign capture    = is_zero_mag(alu_result[7:0]) ? 9'd0 : alu_result;
  assign alu_op1    = alu_op1_reg;
  assign alu_op2    = alu_op2_reg;
  assign alu_opcode = alu_opcode_reg;
  assign out_result = result_reg;
  assign out_err    = err_reg;

  bcd_operand_check u_check (
    .op1    (sel_op1),
    .op2    (in_op2),
    .opcode (in_opcode),
    .err    (chk_err)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    acc_next        = acc_reg;
    alu_op1_next    = alu_op1_reg;
    alu_op2_next    = alu_op2_reg;
    alu_opcode_next = alu_opcode_reg;
    result_next     = result_reg;
    err_next        = err_reg;
    pend_next       = pend_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          pend_next  = chk_err;
          if (chk_err != ERR_NONE) begin
            // Rejected ops spend one cycle in WAIT without touching the ALU.
            cnt_next = '0;
          end else begin
            cnt_next        = CNT_LOAD;
            alu_op1_next    = sel_op1;
            alu_op2_next    = in_op2;
            alu_opcode_next = norm_opcode(in_opcode);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          if (pend_reg != ERR_NONE) begin
            err_next = pend_reg;
          end else begin
            acc_next    = capture;
            result_next = capture;
            err_next    = ERR_NONE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a capture in the same cycle.
    if (clr) begin
      state_next  = IDLE;
      cnt_next    = '0;
      acc_next    = '0;
      pend_next   = ERR_NONE;
      result_next = result_reg;
      err_next    = err_reg;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      acc_reg        <= '0;
      alu_op1_reg    <= '0;
      alu_op2_reg    <= '0;
      alu_opcode_reg <= OP_ADD;
      result_reg     <= '0;
      err_reg        <= ERR_NONE;
      pend_reg       <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      acc_reg        <= acc_next;
      alu_op1_reg    <= alu_op1_next;
      alu_op2_reg    <= alu_op2_next;
      alu_opcode_reg <= alu_opcode_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      pend_reg       <= pend_next;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: dut_a runs with ALU_WAIT=1, dut_b with ALU_WAIT=3.
// A behavioural BCD ALU closes the loop; expected results go through a scoreboard queue.
module tb_alu_sequencer;

  typedef struct {
    logic [8:0] res;
    logic [1:0] err;
    bit         chk_res;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic [8:0] op1, op2;
  logic [2:0] opc;
  logic       use_acc;

  logic       valid_a, ready_a, oready_a, clr_a, ovalid_a, busy_a;
  logic [8:0] aop1_a, aop2_a, ares_a, ores_a;
  logic [2:0] aopc_a;
  logic [1:0] oerr_a;

  logic       valid_b, ready_b, oready_b, clr_b, ovalid_b, busy_b;
  logic [8:0] aop1_b, aop2_b, ares_b, ores_b;
  logic [2:0] aopc_b;
  logic [1:0] oerr_b;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [8:0] m_acc  [2];
  logic [8:0] m_aop1 [2];
  logic [8:0] m_aop2 [2];
  logic [2:0] m_aopc [2];

  always #5 clk = ~clk;

  // Behavioural ALU; it reports equal-operand subtraction as -00.
  function automatic logic [8:0] alu_model(logic [8:0] a, logic [8:0] b, logic [2:0] o);
    int x, y, r, m;
    logic neg;
    x = int'(a[7:4]) * 10 + int'(a[3:0]);
    y = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (a[8]) x = -x;
    if (b[8]) y = -y;
    case (o)
      3'b010:  r = x - y;
      3'b011:  r = x * y;
      3'b100:  r = (y == 0) ? 0 : x / y;
      default: r = x + y;
    endcase
    m   = ((r < 0) ? -r : r) % 100;
    neg = (r < 0) || (o == 3'b010 && r == 0);
    return {neg, 4'(m / 10), 4'(m % 10)};
  endfunction

  assign ares_a = alu_model(aop1_a, aop2_a, aopc_a);
  assign ares_b = alu_model(aop1_b, aop2_b, aopc_b);

  alu_sequencer #(.ALU_WAIT(1)) dut_a (
    .clk(clk), .nrst(nrst), .clr(clr_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_op1(op1), .in_op2(op2), .in_opcode(opc), .in_use_acc(use_acc),
    .alu_op1(aop1_a), .alu_op2(aop2_a), .alu_opcode(aopc_a), .alu_result(ares_a),
    .out_valid(ovalid_a), .out_ready(oready_a), .out_result(ores_a), .out_err(oerr_a),
    .busy(busy_a)
  );

  alu_sequencer #(.ALU_WAIT(3)) dut_b (
    .clk(clk), .nrst(nrst), .clr(clr_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_op1(op1), .in_op2(op2), .in_opcode(opc), .in_use_acc(use_acc),
    .alu_op1(aop1_b), .alu_op2(aop2_b), .alu_opcode(aopc_b), .alu_result(ares_b),
    .out_valid(ovalid_b), .out_ready(oready_b), .out_result(ores_b), .out_err(oerr_b),
    .busy(busy_b)
  );

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 9'h000; m_aop1[i] = 9'h000; m_aop2[i] = 9'h000; m_aopc[i] = 3'b001;
    end
  endtask

  // Push the expected outcome, then hold the request until it is accepted.
  task automatic send(input bit w, input logic [8:0] a, input logic [8:0] b,
                      input logic [2:0] o, input logic ua);
    logic [8:0] sel, r;
    logic [1:0] err;
    logic [2:0] om;
    bit         got;
    exp_t       e;
    sel = ua ? m_acc[w] : a;
    om  = (o >= 3'd1 && o <= 3'd4) ? o : 3'b001;
    err = 2'b00;
`ifdef ALU_SEQ_DIGIT_CHECK_EN
    if (sel[7:4] > 4'd9 || sel[3:0] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9) err = 2'b10;
`endif
    if (o == 3'b100 && b[7:0] == 8'd0) err = 2'b01;
    if (err == 2'b00) begin
      r = alu_model(sel, b, om);
      if (r[7:0] == 8'd0) r = 9'h000;
      m_acc[w] = r; m_aop1[w] = sel; m_aop2[w] = b; m_aopc[w] = om;
      e = '{r, 2'b00, 1'b1};
    end else begin
      e = '{9'h000, err, 1'b0};
    end
    sb.push_back(e);
    op1 = a; op2 = b; opc = o; use_acc = ua;
    if (w) valid_b = 1'b1; else valid_a = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      got = w ? ready_b : ready_a;
      @(posedge clk); #1;
    end
    valid_a = 1'b0; valid_b = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL send_accept: dut%0d in_ready stayed 0, required 1", w); end
  endtask

  // Wait for out_valid (bounded), sample outputs and pop the matching expectation.
  task automatic collect(input bit w, input int budget, output int cyc, output bit ok,
                         output logic [8:0] got_res, output logic [1:0] got_err, output exp_t e);
    cyc = 0; ok = 1'b0;
    while (cyc < budget) begin
      if ((w ? ovalid_b : ovalid_a) === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    got_res = w ? ores_b : ores_a;
    got_err = w ? oerr_b : oerr_a;
    e = '{9'h000, 2'b00, 1'b0};
    if (sb.size() > 0) e = sb.pop_front();
    $display("txn dut%0d cycles=%0d valid=%0d result=%h err=%0d exp_result=%h exp_err=%0d",
             w, cyc, ok, got_res, got_err, e.res, e.err);
  endtask

  task automatic consume(input bit w);
    if (w) oready_b = 1'b1; else oready_a = 1'b1;
    @(posedge clk); #1;
    oready_a = 1'b0; oready_b = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0; valid_a = 0; valid_b = 0; oready_a = 0; oready_b = 0; clr_a = 0; clr_b = 0;
    op1 = '0; op2 = '0; opc = 3'b001; use_acc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%0d want=1", ready_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0d want=0", busy_a); end
    total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%0d want=0", ovalid_a); end
    total++; if (ores_a !== 9'h000) begin bad++; $display("FAIL reset_result: got=%h want=000", ores_a); end
    total++; if (oerr_a !== 2'b00) begin bad++; $display("FAIL reset_err: got=%0d want=0", oerr_a); end
    total++; if (aopc_a !== 3'b001) begin bad++; $display("FAIL reset_opcode: got=%0d want=1", aopc_a); end
    total++; if ({aop1_a, aop2_a} !== 18'h0) begin bad++; $display("FAIL reset_aluops: got=%h/%h want=000/000", aop1_a, aop2_a); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b: got=%0d want=0", busy_b); end
  endtask

  task automatic test_add;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e;
    send(1'b0, 9'h012, 9'h007, 3'b001, 1'b0);
    total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL add_early_valid: got=%0d want=0", ovalid_a); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL add_busy: got=%0d want=1", busy_a); end
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || cyc != 1) begin bad++; $display("FAIL add_latency: got=%0d want=1", cyc); end
    total++; if (gr !== e.res) begin bad++; $display("FAIL add_result: got=%h want=%h", gr, e.res); end
    total++; if (ge !== e.err) begin bad++; $display("FAIL add_err: got=%0d want=%0d", ge, e.err); end
    consume(1'b0);
    total++; if (ovalid_a !== 1'b0) begin bad++; $display("FAIL add_release: got=%0d want=0", ovalid_a); end
  endtask

  task automatic test_sub;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e;
    send(1'b0, 9'h005, 9'h012, 3'b010, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL sub_negative: got=%h want=%h", gr, e.res); end
    consume(1'b0);
    send(1'b0, 9'h007, 9'h007, 3'b010, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL sub_zero_sign: got=%h want=%h", gr, e.res); end
    consume(1'b0);
  endtask

  task automatic test_chain;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e; logic [8:0] want_op1;
    send(1'b0, 9'h012, 9'h007, 3'b001, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL chain_seed: got=%h want=%h", gr, e.res); end
    consume(1'b0);
    want_op1 = m_acc[0];
    send(1'b0, 9'h1FF, 9'h003, 3'b011, 1'b1);
    total++; if (aop1_a !== want_op1) begin bad++; $display("FAIL chain_alu_op1: got=%h want=%h", aop1_a, want_op1); end
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL chain_result: got=%h want=%h", gr, e.res); end
    consume(1'b0);
  endtask

  task automatic test_div0;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e;
    send(1'b0, 9'h045, 9'h000, 3'b100, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || cyc != 1) begin bad++; $display("FAIL div0_latency: got=%0d want=1", cyc); end
    total++; if (ge !== e.err) begin bad++; $display("FAIL div0_err: got=%0d want=%0d", ge, e.err); end
    total++; if ({aop1_a, aop2_a, aopc_a} !== {m_aop1[0], m_aop2[0], m_aopc[0]}) begin
      bad++; $display("FAIL div0_alu_hold: got=%h/%h/%0d want=%h/%h/%0d",
                      aop1_a, aop2_a, aopc_a, m_aop1[0], m_aop2[0], m_aopc[0]);
    end
    consume(1'b0);
    send(1'b0, 9'h000, 9'h000, 3'b001, 1'b1);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res || ge !== e.err) begin
      bad++; $display("FAIL div0_acc_kept: got=%h/%0d want=%h/%0d", gr, ge, e.res, e.err);
    end
    consume(1'b0);
  endtask

  task automatic test_bad_opcode;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e;
    send(1'b0, 9'h010, 9'h005, 3'b111, 1'b0);
    total++; if (aopc_a !== 3'b001) begin bad++; $display("FAIL badop_opcode: got=%0d want=1", aopc_a); end
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL badop_result: got=%h want=%h", gr, e.res); end
    consume(1'b0);
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e; int unstable;
    send(1'b0, 9'h021, 9'h030, 3'b001, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL bp_result: got=%h want=%h", gr, e.res); end
    unstable = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ovalid_a !== 1'b1 || ores_a !== e.res || oerr_a !== e.err || ready_a !== 1'b0) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold: unstable_cycles=%0d want=0", unstable); end
    consume(1'b0);
    total++; if (ready_a !== 1'b1 || ovalid_a !== 1'b0) begin
      bad++; $display("FAIL bp_after_handshake: ready=%0d valid=%0d want 1/0", ready_a, ovalid_a);
    end
    send(1'b0, 9'h002, 9'h004, 3'b011, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || cyc != 1 || gr !== e.res) begin
      bad++; $display("FAIL b2b_result: got=%h cyc=%0d want=%h cyc=1", gr, cyc, e.res);
    end
    consume(1'b0);
  endtask

  task automatic test_clr;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e; int leaked;
    send(1'b1, 9'h020, 9'h003, 3'b001, 1'b0);
    collect(1'b1, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || cyc != 3) begin bad++; $display("FAIL wait3_latency: got=%0d want=3", cyc); end
    total++; if (gr !== e.res) begin bad++; $display("FAIL wait3_result: got=%h want=%h", gr, e.res); end
    consume(1'b1);
    send(1'b1, 9'h1FF, 9'h010, 3'b001, 1'b1);
    @(posedge clk); #1;
    total++; if (aop1_b !== m_aop1[1]) begin bad++; $display("FAIL wait3_hold: got=%h want=%h", aop1_b, m_aop1[1]); end
    clr_b = 1'b1; valid_b = 1'b1;
    total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL clr_ready: got=%0d want=0", ready_b); end
    @(posedge clk); #1;
    clr_b = 1'b0; valid_b = 1'b0;
    void'(sb.pop_back());
    m_acc[1] = 9'h000;
    total++; if (busy_b !== 1'b0 || ovalid_b !== 1'b0) begin
      bad++; $display("FAIL clr_idle: busy=%0d valid=%0d want 0/0", busy_b, ovalid_b);
    end
    leaked = 0;
    repeat (4) begin @(posedge clk); #1; if (ovalid_b !== 1'b0) leaked++; end
    total++; if (leaked != 0) begin bad++; $display("FAIL clr_discard: valid_cycles=%0d want=0", leaked); end
    send(1'b1, 9'h000, 9'h001, 3'b001, 1'b1);
    collect(1'b1, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL clr_acc: got=%h want=%h", gr, e.res); end
    consume(1'b1);
  endtask

`ifdef ALU_SEQ_DIGIT_CHECK_EN
  task automatic test_digit;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e;
    send(1'b0, 9'h0A3, 9'h001, 3'b001, 1'b0);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || ge !== e.err) begin bad++; $display("FAIL digit_err: got=%0d want=%0d", ge, e.err); end
    consume(1'b0);
  endtask
`endif

  task automatic test_reset_mid;
    int cyc; bit ok; logic [8:0] gr; logic [1:0] ge; exp_t e; int leaked;
    send(1'b1, 9'h044, 9'h002, 3'b011, 1'b0);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    total++; if (ovalid_b !== 1'b0 || busy_b !== 1'b0 || aopc_b !== 3'b001 || aop1_b !== 9'h000) begin
      bad++; $display("FAIL async_reset: valid=%0d busy=%0d opc=%0d op1=%h want 0/0/1/000",
                      ovalid_b, busy_b, aopc_b, aop1_b);
    end
    void'(sb.pop_back());
    model_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
    leaked = 0;
    repeat (4) begin @(posedge clk); #1; if (ovalid_b !== 1'b0) leaked++; end
    total++; if (leaked != 0) begin bad++; $display("FAIL reset_no_partial: valid_cycles=%0d want=0", leaked); end
    send(1'b0, 9'h000, 9'h005, 3'b001, 1'b1);
    collect(1'b0, 10, cyc, ok, gr, ge, e);
    total++; if (!ok || gr !== e.res) begin bad++; $display("FAIL reset_acc: got=%h want=%h", gr, e.res); end
    consume(1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_div0();
    test_bad_opcode();
    test_back_to_back();
    test_clr();
`ifdef ALU_SEQ_DIGIT_CHECK_EN
    test_digit();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
